// File: rtl/pe_ctrl_pkg.sv
// Shared types and select-pattern constants for the PE_8IP sequencer.
// Patterns pack m9 in the MSBs down to m0 in the LSBs.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SVP,
        ST_AGGR,
        ST_DONE
    } state_t;

    localparam logic [1:0] SEL_X          = 2'd0;
    localparam logic [1:0] SEL_MULT       = 2'd1;
    localparam logic [1:0] SEL_AGGR       = 2'd2;
    localparam logic [1:0] SEL_ZERO       = 2'd3;
    localparam logic [1:0] SEL_OUT_ADDSUB = 2'd0;

    localparam logic [19:0] SVP_PAT = {
        SEL_ZERO, SEL_OUT_ADDSUB,
        SEL_ZERO, SEL_ZERO,
        SEL_MULT, SEL_MULT,
        {4{SEL_X}}
    };

    localparam logic [19:0] AGGR_PAT = {
        SEL_OUT_ADDSUB, SEL_OUT_ADDSUB,
        {4{SEL_AGGR}},
        {4{SEL_MULT}}
    };

    localparam logic [19:0] STOP_PAT = {
        SEL_AGGR, SEL_AGGR,
        {8{SEL_ZERO}}
    };

endpackage

// File: rtl/pe_8ip_sequencer.sv
// Sequences one PE_8IP through an SVP pass and an aggregation pass,
// then hands the captured result back over valid/ready.
module pe_8ip_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int SVP_CYCLES  = 21,
    parameter int AGGR_CYCLES = 38,
    parameter int CNT_W = $clog2(
        ((SVP_CYCLES > AGGR_CYCLES) ? SVP_CYCLES : AGGR_CYCLES) + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_use_int,
    input  logic [2:0]  cmd_rounding,
    input  logic        cmd_tininess,
    input  logic        abort,
    output logic [19:0] io_m_sel,
    output logic [3:0]  io_addsub_op,
    output logic        io_use_int,
    output logic [2:0]  io_rounding,
    output logic        io_tininess,
    input  logic [31:0] pe_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy
);

    localparam logic [CNT_W-1:0] SVP_LAST  = CNT_W'(SVP_CYCLES - 1);
    localparam logic [CNT_W-1:0] AGGR_LAST = CNT_W'(AGGR_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cfg_load;
    logic             res_load;
    logic             cfg_use_int;
    logic [2:0]       cfg_rounding;
    logic             cfg_tininess;
    logic [31:0]      res_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            cfg_use_int  <= 1'b0;
            cfg_rounding <= 3'd0;
            cfg_tininess <= 1'b0;
            res_q        <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (cfg_load) begin
                cfg_use_int  <= cmd_use_int;
                cfg_rounding <= cmd_rounding;
                cfg_tininess <= cmd_tininess;
            end
            if (res_load) begin
                res_q <= pe_out;
            end
        end
    end

    // abort outranks every other transition, including acceptance
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cfg_load  = 1'b0;
        res_load  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!abort && cmd_valid) begin
                    state_nxt = ST_SVP;
                    cnt_nxt   = '0;
                    cfg_load  = 1'b1;
                end
            end
            ST_SVP: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == SVP_LAST) begin
                    state_nxt = ST_AGGR;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_AGGR: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == AGGR_LAST) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                    res_load  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                if (abort || res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        io_m_sel = STOP_PAT;
        unique case (1'b1)
            (state == ST_SVP):  io_m_sel = SVP_PAT;
            (state == ST_AGGR): io_m_sel = AGGR_PAT;
            default:            io_m_sel = STOP_PAT;
        endcase
    end

    assign io_addsub_op = 4'd0;
    assign io_use_int   = cfg_use_int;
    assign io_rounding  = cfg_rounding;
    assign io_tininess  = cfg_tininess;
    assign cmd_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign res_valid    = (state == ST_DONE);
    assign res_data     = res_q;

endmodule

// File: tb/tb_pe_8ip_sequencer.sv
// Directed bench for pe_8ip_sequencer; PE result is driven by the bench.
// Cycle k counts negedges after the accepting posedge.
module tb_pe_8ip_sequencer;

    localparam logic [19:0] P_STOP = 20'hAFFFF;
    localparam logic [19:0] P_SVP  = 20'hCF500;
    localparam logic [19:0] P_AGGR = 20'h0AA55;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_use_int;
    logic [2:0]  cmd_rounding;
    logic        cmd_tininess;
    logic        abort;
    logic [19:0] io_m_sel;
    logic [3:0]  io_addsub_op;
    logic        io_use_int;
    logic [2:0]  io_rounding;
    logic        io_tininess;
    logic [31:0] pe_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pe_8ip_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_use_int  (cmd_use_int),
        .cmd_rounding (cmd_rounding),
        .cmd_tininess (cmd_tininess),
        .abort        (abort),
        .io_m_sel     (io_m_sel),
        .io_addsub_op (io_addsub_op),
        .io_use_int   (io_use_int),
        .io_rounding  (io_rounding),
        .io_tininess  (io_tininess),
        .pe_out       (pe_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .busy         (busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_job(input logic ui,
                           input logic [2:0] rnd,
                           input logic tin,
                           input logic [31:0] pv);
        int bad_pat = 0;
        int bad_cfg = 0;
        int bad_vld = 0;
        logic [19:0] ep;
        cmd_valid    = 1'b1;
        cmd_use_int  = ui;
        cmd_rounding = rnd;
        cmd_tininess = tin;
        @(negedge clock);
        cmd_valid    = 1'b0;
        cmd_use_int  = ~ui;
        cmd_rounding = ~rnd;
        cmd_tininess = ~tin;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clock);
            ep = (k <= 21) ? P_SVP : (k <= 59) ? P_AGGR : P_STOP;
            if (io_m_sel !== ep || io_addsub_op !== 4'd0) bad_pat++;
            if (io_use_int !== ui || io_rounding !== rnd
                || io_tininess !== tin) bad_cfg++;
            if (res_valid !== (k == 60) || busy !== 1'b1
                || cmd_ready !== 1'b0) bad_vld++;
            pe_out = (k == 59) ? pv : ~pv;
        end
        chk("pattern_seq", bad_pat, 0);
        chk("cfg_hold", bad_cfg, 0);
        chk("valid_seq", bad_vld, 0);
        chk("res_data", res_data, pv);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        chk("hs_cmd_ready", cmd_ready, 1);
        chk("hs_res_valid", res_valid, 0);
        chk("hs_m_sel", io_m_sel, P_STOP);
    endtask

    initial begin
        int bad;
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_use_int  = 1'b0;
        cmd_rounding = 3'd0;
        cmd_tininess = 1'b0;
        abort        = 1'b0;
        pe_out       = 32'd0;
        res_ready    = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Test 1: reset state
        chk("rst_m_sel", io_m_sel, P_STOP);
        chk("rst_addsub", io_addsub_op, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cfg", {io_use_int, io_rounding, io_tininess}, 0);
        chk("rst_res_data", res_data, 0);

        // Test 2: INT job
        run_job(1'b1, 3'd7, 1'b1, 32'h0000_1AD0);
        handshake();
        chk("cfg_kept_idle", {io_use_int, io_rounding, io_tininess},
            5'b1_111_1);

        // Test 3: FP job
        run_job(1'b0, 3'd4, 1'b0, 32'h45D6_8000);

        // Test 4: backpressure in DONE with a competing command
        cmd_valid    = 1'b1;
        cmd_use_int  = 1'b1;
        cmd_rounding = 3'd2;
        cmd_tininess = 1'b1;
        pe_out       = 32'h1111_2222;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (res_valid !== 1'b1 || res_data !== 32'h45D6_8000
                || io_m_sel !== P_STOP || cmd_ready !== 1'b0
                || io_rounding !== 3'd4 || io_use_int !== 1'b0) bad++;
        end
        chk("bp_stable", bad, 0);
        cmd_valid = 1'b0;
        handshake();

        // Test 5a: abort during SVP
        cmd_valid    = 1'b1;
        cmd_use_int  = 1'b1;
        cmd_rounding = 3'd1;
        cmd_tininess = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("ab_in_svp", io_m_sel, P_SVP);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_cmd_ready", cmd_ready, 1);
        chk("ab_res_data", res_data, 32'h45D6_8000);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (res_valid !== 1'b0 || io_m_sel !== P_STOP) bad++;
        end
        chk("ab_quiet", bad, 0);

        // Test 5b: abort beats cmd_valid in IDLE
        cmd_valid    = 1'b1;
        abort        = 1'b1;
        cmd_use_int  = 1'b0;
        cmd_rounding = 3'd5;
        cmd_tininess = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        chk("ab_prio_busy", busy, 0);
        chk("ab_prio_cfg", {io_use_int, io_rounding, io_tininess},
            5'b1_001_0);

        // Test 5c: reset during AGGR
        cmd_valid    = 1'b1;
        cmd_use_int  = 1'b1;
        cmd_rounding = 3'd6;
        cmd_tininess = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (29) @(negedge clock);
        chk("rs_in_aggr", io_m_sel, P_AGGR);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rs_m_sel", io_m_sel, P_STOP);
        chk("rs_res_data", res_data, 0);
        chk("rs_cfg", {io_use_int, io_rounding, io_tininess}, 0);
        chk("rs_busy", busy, 0);
        chk("rs_cmd_ready", cmd_ready, 1);
        chk("rs_res_valid", res_valid, 0);

        // Test 6: back-to-back with cmd_valid and res_ready held high
        cmd_valid    = 1'b1;
        res_ready    = 1'b1;
        cmd_use_int  = 1'b1;
        cmd_rounding = 3'd2;
        cmd_tininess = 1'b0;
        pe_out       = 32'h1234_5678;
        @(negedge clock);
        cmd_use_int  = 1'b0;
        cmd_rounding = 3'd3;
        cmd_tininess = 1'b1;
        bad = 0;
        for (int k = 1; k <= 61; k++) begin
            if (k > 1) @(negedge clock);
            if ({io_use_int, io_rounding, io_tininess} !== 5'b1_010_0)
                bad++;
            if (k == 60) chk("b2b_valid", res_valid, 1);
            if (k == 60) chk("b2b_data", res_data, 32'h1234_5678);
        end
        chk("b2b_cfg_hold", bad, 0);
        chk("b2b_idle", cmd_ready, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        chk("b2b_accept", io_m_sel, P_SVP);
        chk("b2b_cfg_new", {io_use_int, io_rounding, io_tininess},
            5'b0_011_1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("end_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
